// File: rtl/ob_pkg.sv
// ob_pkg: shared types and constants for the order-book multi-port front end.
//   cmd_t / rsp_t : core command / response words (128 bits each)
//   pid_w()       : port-ID width, max(1, clog2(P))
//   MPORT_*       : default ob_mport sizing
package ob_pkg;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] oid;
        logic [31:0] px;
        logic [31:0] qty;
        logic [23:0] rsvd;
    } cmd_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [31:0] oid;
        logic [31:0] px;
        logic [31:0] qty;
        logic [23:0] rsvd;
    } rsp_t;

    localparam int MPORT_P          = 4;
    localparam int MPORT_IN_N       = 4;
    localparam int MPORT_OUT_N      = 4;
    localparam int MPORT_INFLIGHT_N = 8;

    // A single port still needs a 1-bit ID so tag entries never collapse to zero width.
    function automatic int pid_w(input int p);
        return ($clog2(p) < 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/libv_queue.sv
// libv_queue: synchronous FIFO with registered full/empty flags.
//   clk, rst       : clock, synchronous active-high reset
//   push_i/data_i  : write; accepted when not full, or when full with a same-cycle pop
//   pop_i/data_o   : read; data_o is the current head (first-word fall-through)
//   empty_o/full_o : registered occupancy flags, derived from next-state count
module libv_queue #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    // Explicit wrap so non-power-of-2 depths work too.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
        return (a == AW'(N - 1)) ? '0 : a + 1'b1;
    endfunction

    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop)  rd_q <= inc(rd_q);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(N));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/ob_mport_rr_arb.sv
// ob_mport_rr_arb: P-way round-robin arbiter.
//   req_i     : per-port request
//   en_i      : grant permitted this cycle
//   gnt_vld_o : a grant is issued
//   gnt_id_o  : granted port; search starts at the internal pointer,
//               which moves to gnt_id+1 (mod P) after each grant
module ob_mport_rr_arb
    import ob_pkg::*;
#(
    parameter int P     = 4,
    parameter int PID_W = pid_w(P)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P-1:0]     req_i,
    input  logic             en_i,
    output logic             gnt_vld_o,
    output logic [PID_W-1:0] gnt_id_o
);
    logic [PID_W-1:0] ptr_q;
    logic [PID_W:0]   sum;
    logic             found;

    always_comb begin
        gnt_id_o = '0;
        found    = 1'b0;
        sum      = '0;
        for (int k = 0; k < P; k++) begin
            sum = {1'b0, ptr_q} + (PID_W + 1)'(k);
            if (sum >= (PID_W + 1)'(P)) sum = sum - (PID_W + 1)'(P);
            if (!found && req_i[sum[PID_W-1:0]]) begin
                found    = 1'b1;
                gnt_id_o = sum[PID_W-1:0];
            end
        end
    end

    assign gnt_vld_o = en_i & found;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (gnt_vld_o) begin
            ptr_q <= (gnt_id_o == PID_W'(P - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

endmodule

// File: rtl/ob_mport.sv
// ob_mport: P-port front end for the order-book core.
//   cmd_vld_r/cmd_r   : per-port command push into ingress queue i
//   cmd_full_r        : per-port ingress full (registered)
//   rsp_vld/rsp       : per-port egress head; rsp_accept pops it
//   core_cmd_vld/_cmd : registered one-cycle command pulse to the core
//   core_cmd_full_r   : core backpressure
//   core_rsp_*        : core response stream; core_rsp_last ends a command
//   core_rsp_accept   : response consumed this cycle
//   err_ovf_r         : sticky per-port push-while-full
//   err_orphan_r      : sticky response with nothing in flight
// A tag FIFO of port IDs, pushed at issue and popped on the last response,
// routes core responses back in command order.
module ob_mport
    import ob_pkg::*;
#(
    parameter int P          = MPORT_P,
    parameter int CMD_W      = $bits(cmd_t),
    parameter int RSP_W      = $bits(rsp_t),
    parameter int IN_N       = MPORT_IN_N,
    parameter int OUT_N      = MPORT_OUT_N,
    parameter int INFLIGHT_N = MPORT_INFLIGHT_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P-1:0]       cmd_vld_r,
    input  logic [P*CMD_W-1:0] cmd_r,
    output logic [P-1:0]       cmd_full_r,
    input  logic [P-1:0]       rsp_accept,
    output logic [P-1:0]       rsp_vld,
    output logic [P*RSP_W-1:0] rsp,
    output logic               core_cmd_vld,
    output logic [CMD_W-1:0]   core_cmd,
    input  logic               core_cmd_full_r,
    input  logic               core_rsp_vld,
    input  logic [RSP_W-1:0]   core_rsp,
    input  logic               core_rsp_last,
    output logic               core_rsp_accept,
    output logic [P-1:0]       err_ovf_r,
    output logic               err_orphan_r
);
    localparam int PID_W = pid_w(P);

    logic [P-1:0][CMD_W-1:0] in_head;
    logic [P-1:0]            in_empty, in_full, in_push, in_pop;
    logic [P-1:0][RSP_W-1:0] egr_head;
    logic [P-1:0]            egr_empty, egr_full, egr_push, egr_pop;

    logic                    gnt_vld;
    logic [PID_W-1:0]        gnt_id;
    logic [PID_W-1:0]        tag_head;
    logic                    tag_empty, tag_full, tag_pop;
    logic                    acc;

    logic                    core_cmd_vld_q;
    logic [CMD_W-1:0]        core_cmd_q;
    logic [P-1:0]            err_ovf_q, err_ovf_d;
    logic                    err_orphan_q, err_orphan_d;

    // ---------------- ingress ----------------
    // The queue's full flag is registered from next-state occupancy, so it
    // already is the cmd_full_r view including this cycle's push and pop.
    for (genvar gi = 0; gi < P; gi++) begin : g_in
        assign in_push[gi] = cmd_vld_r[gi] & ~in_full[gi];
        assign in_pop[gi]  = gnt_vld & (gnt_id == PID_W'(gi));
        libv_queue #(.W(CMD_W), .N(IN_N)) u_q (
            .clk    (clk),
            .rst    (rst),
            .push_i (in_push[gi]),
            .data_i (cmd_r[gi*CMD_W +: CMD_W]),
            .pop_i  (in_pop[gi]),
            .data_o (in_head[gi]),
            .empty_o(in_empty[gi]),
            .full_o (in_full[gi])
        );
    end

    assign cmd_full_r = in_full;

    // ---------------- issue ----------------
    ob_mport_rr_arb #(.P(P), .PID_W(PID_W)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (~in_empty),
        .en_i     (~core_cmd_full_r & ~tag_full),
        .gnt_vld_o(gnt_vld),
        .gnt_id_o (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            core_cmd_vld_q <= 1'b0;
            core_cmd_q     <= '0;
        end else begin
            core_cmd_vld_q <= gnt_vld;
            if (gnt_vld) core_cmd_q <= in_head[gnt_id];
        end
    end

    assign core_cmd_vld = core_cmd_vld_q;
    assign core_cmd     = core_cmd_q;

    // ---------------- tag FIFO ----------------
    libv_queue #(.W(PID_W), .N(INFLIGHT_N)) u_tag (
        .clk    (clk),
        .rst    (rst),
        .push_i (gnt_vld),
        .data_i (gnt_id),
        .pop_i  (tag_pop),
        .data_o (tag_head),
        .empty_o(tag_empty),
        .full_o (tag_full)
    );

    // Orphans (tag FIFO empty) are always accepted so the core never wedges.
    // Egress space is judged on current occupancy only.
    assign acc             = ~rst & core_rsp_vld & (tag_empty | ~egr_full[tag_head]);
    assign tag_pop         = acc & ~tag_empty & core_rsp_last;
    assign core_rsp_accept = acc;

    // ---------------- egress ----------------
    for (genvar gi = 0; gi < P; gi++) begin : g_egr
        assign egr_push[gi] = acc & ~tag_empty & (tag_head == PID_W'(gi));
        assign egr_pop[gi]  = ~egr_empty[gi] & rsp_accept[gi];
        libv_queue #(.W(RSP_W), .N(OUT_N)) u_q (
            .clk    (clk),
            .rst    (rst),
            .push_i (egr_push[gi]),
            .data_i (core_rsp),
            .pop_i  (egr_pop[gi]),
            .data_o (egr_head[gi]),
            .empty_o(egr_empty[gi]),
            .full_o (egr_full[gi])
        );
        assign rsp_vld[gi]               = ~egr_empty[gi];
        assign rsp[gi*RSP_W +: RSP_W]    = egr_head[gi];
    end

    // ---------------- sticky errors ----------------
    assign err_ovf_d    = err_ovf_q | (cmd_vld_r & in_full);
    assign err_orphan_d = err_orphan_q | (acc & tag_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            err_ovf_q    <= err_ovf_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_ovf_r    = err_ovf_q;
    assign err_orphan_r = err_orphan_q;

endmodule

// File: tb/tb_ob_mport.sv
// tb_ob_mport: directed self-checking bench for ob_mport (P=4, IN_N=4,
// OUT_N=4, INFLIGHT_N=8). Inputs change 1ns after a rising edge; outputs
// are sampled there too.
module tb_ob_mport;
    localparam int P  = 4;
    localparam int CW = 128;
    localparam int RW = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    cmd_vld_r;
    logic [P*CW-1:0] cmd_r;
    logic [P-1:0]    cmd_full_r;
    logic [P-1:0]    rsp_accept;
    logic [P-1:0]    rsp_vld;
    logic [P*RW-1:0] rsp;
    logic            core_cmd_vld;
    logic [CW-1:0]   core_cmd;
    logic            core_cmd_full_r;
    logic            core_rsp_vld;
    logic [RW-1:0]   core_rsp;
    logic            core_rsp_last;
    logic            core_rsp_accept;
    logic [P-1:0]    err_ovf_r;
    logic            err_orphan_r;

    int npass  = 0;
    int ntotal = 0;

    ob_mport dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_vld_r      (cmd_vld_r),
        .cmd_r          (cmd_r),
        .cmd_full_r     (cmd_full_r),
        .rsp_accept     (rsp_accept),
        .rsp_vld        (rsp_vld),
        .rsp            (rsp),
        .core_cmd_vld   (core_cmd_vld),
        .core_cmd       (core_cmd),
        .core_cmd_full_r(core_cmd_full_r),
        .core_rsp_vld   (core_rsp_vld),
        .core_rsp       (core_rsp),
        .core_rsp_last  (core_rsp_last),
        .core_rsp_accept(core_rsp_accept),
        .err_ovf_r      (err_ovf_r),
        .err_orphan_r   (err_orphan_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] mk(input int p, input int k);
        return {96'hC0DE, 16'(p), 16'(k)};
    endfunction

    function automatic logic [127:0] rd(input int k);
        return {96'hBEEF, 32'(k)};
    endfunction

    task automatic set_cmd(input int p, input logic [127:0] v);
        cmd_r[p*CW +: CW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_vld_r = '0; cmd_r = '0; rsp_accept = '0; core_cmd_full_r = 1'b0;
        core_rsp_vld = 1'b0; core_rsp = '0; core_rsp_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rsp_slot(input int p);
        return rsp[p*RW +: RW];
    endfunction

    logic [127:0] got[$];
    logic [127:0] lastcmd;
    int           b;
    int           nissue;

    initial begin
        // ---- reset state ----
        do_reset();
        rst = 1'b1;
        core_rsp_vld = 1'b1;   // accept must stay low while in reset
        #1;
        chk("rst_full", cmd_full_r, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_core_vld", core_cmd_vld, 0);
        chk("rst_core_cmd", core_cmd, 0);
        chk("rst_acc", core_rsp_accept, 0);
        chk("rst_err", {err_ovf_r, err_orphan_r}, 0);
        core_rsp_vld = 1'b0;
        rst = 1'b0;

        // ---- single port: port 2, 2-cycle issue latency ----
        do_reset();
        cmd_vld_r = 4'b0100; set_cmd(2, mk(2, 7));
        tick();
        cmd_vld_r = '0;
        chk("lat_t1_vld", core_cmd_vld, 0);
        tick();
        chk("lat_t2_vld", core_cmd_vld, 1);
        chk("lat_t2_cmd", core_cmd, mk(2, 7));
        tick();
        chk("lat_pulse", core_cmd_vld, 0);
        core_rsp_vld = 1'b1; core_rsp = rd(70); core_rsp_last = 1'b1;
        #1;
        chk("single_acc", core_rsp_accept, 1);
        tick();
        core_rsp_vld = 1'b0;
        chk("single_rsp_vld", rsp_vld, 4'b0100);
        chk("single_rsp", rsp_slot(2), rd(70));
        rsp_accept = 4'b0100;
        tick();
        rsp_accept = '0;
        chk("single_pop", rsp_vld, 0);

        // ---- fairness: 3 commands per port, RR from pointer 0 ----
        do_reset();
        core_cmd_full_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_vld_r = 4'hF;
            for (int p = 0; p < P; p++) set_cmd(p, mk(p, k));
            tick();
        end
        cmd_vld_r = '0;
        core_cmd_full_r = 1'b0;
        rsp_accept = 4'hF;
        core_rsp_last = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rr_vld%0d", i), core_cmd_vld, 1);
            chk($sformatf("rr_cmd%0d", i), core_cmd, mk(i % 4, i / 4));
            core_rsp_vld = core_cmd_vld;   // core answers each command immediately
            core_rsp = rd(i);
        end
        tick();
        core_rsp_vld = 1'b0;
        chk("rr_done", core_cmd_vld, 0);
        tick();
        chk("rr_no_orphan", err_orphan_r, 0);
        rsp_accept = '0;

        // ---- multi-response: X on port 1 (3 beats), Y on port 3 (1 beat) ----
        do_reset();
        cmd_vld_r = 4'b1010; set_cmd(1, mk(1, 0)); set_cmd(3, mk(3, 0));
        tick();
        cmd_vld_r = '0;
        tick();
        chk("mr_issue_x", core_cmd, mk(1, 0));
        tick();
        chk("mr_issue_y", core_cmd, mk(3, 0));
        for (int k = 0; k < 4; k++) begin
            core_rsp_vld = 1'b1; core_rsp = rd(10 + k); core_rsp_last = (k >= 2);
            tick();
        end
        core_rsp_vld = 1'b0;
        chk("mr_vld", rsp_vld, 4'b1010);
        chk("mr_y", rsp_slot(3), rd(13));
        rsp_accept = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mr_x%0d", k), rsp_slot(1), rd(10 + k));
            tick();
        end
        rsp_accept = '0;
        chk("mr_x_drained", rsp_vld, 4'b1000);

        // ---- egress backpressure: 6 beats into OUT_N=4 ----
        do_reset();
        cmd_vld_r = 4'b0001; set_cmd(0, mk(0, 0));
        tick();
        cmd_vld_r = '0;
        tick();
        b = 0;
        got.delete();
        for (int cyc = 0; cyc < 14; cyc++) begin
            rsp_accept = (cyc >= 6) ? 4'b0001 : 4'b0000;
            core_rsp_vld = (b < 6); core_rsp = rd(20 + b); core_rsp_last = (b == 5);
            #1;
            if (cyc == 3) chk("bp_acc3", core_rsp_accept, 1);
            if (cyc == 4) chk("bp_acc4_full", core_rsp_accept, 0);
            if (cyc == 6) chk("bp_acc6_samepop", core_rsp_accept, 0);
            if (cyc == 7) chk("bp_acc7_resume", core_rsp_accept, 1);
            if (core_rsp_accept) b++;
            if (rsp_vld[0] && rsp_accept[0]) got.push_back(rsp_slot(0));
            tick();
        end
        core_rsp_vld = 1'b0;
        rsp_accept = '0;
        chk("bp_beats_sent", b, 6);
        chk("bp_got_n", got.size(), 6);
        for (int k = 0; k < 6 && k < got.size(); k++) chk($sformatf("bp_got%0d", k), got[k], rd(20 + k));
        chk("bp_empty", rsp_vld, 0);

        // ---- ingress overflow ----
        do_reset();
        core_cmd_full_r = 1'b1;
        cmd_vld_r = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_cmd(0, mk(0, k));
            tick();
            if (k == 2) chk("ovf_full3", cmd_full_r, 0);
            if (k == 3) begin
                chk("ovf_full4", cmd_full_r, 4'b0001);
                chk("ovf_err_pre", err_ovf_r, 0);
            end
        end
        chk("ovf_err", err_ovf_r, 4'b0001);
        cmd_vld_r = '0;
        core_cmd_full_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("ovf_cmd%0d", k), core_cmd, mk(0, k));
            if (k == 0) chk("ovf_full_clr", cmd_full_r, 0);
        end
        tick();
        chk("ovf_5th_dropped", core_cmd_vld, 0);

        // ---- in-flight limit ----
        do_reset();
        core_cmd_full_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_vld_r = 4'hF;
            for (int p = 0; p < P; p++) set_cmd(p, mk(p, k));
            tick();
        end
        cmd_vld_r = '0;
        core_cmd_full_r = 1'b0;
        nissue = 0;
        lastcmd = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (core_cmd_vld) begin
                nissue++;
                lastcmd = core_cmd;
            end
        end
        chk("infl_count", nissue, 8);
        chk("infl_last", lastcmd, mk(3, 1));
        core_rsp_vld = 1'b1; core_rsp = rd(99); core_rsp_last = 1'b1;
        tick();
        core_rsp_vld = 1'b0;
        chk("infl_still_stalled", core_cmd_vld, 0);
        tick();
        chk("infl_resume_vld", core_cmd_vld, 1);
        chk("infl_resume_cmd", core_cmd, mk(0, 2));

        // ---- orphan response ----
        do_reset();
        core_rsp_vld = 1'b1; core_rsp = rd(5); core_rsp_last = 1'b1;
        #1;
        chk("orph_acc", core_rsp_accept, 1);
        tick();
        core_rsp_vld = 1'b0;
        chk("orph_err", err_orphan_r, 1);
        chk("orph_no_rsp", rsp_vld, 0);

        // ---- reset mid-traffic (orphan error still set from above) ----
        cmd_vld_r = 4'hF;
        for (int p = 0; p < P; p++) set_cmd(p, mk(p, 9));
        tick();
        cmd_vld_r = '0;
        tick();
        chk("mid_pre_vld", core_cmd_vld, 1);
        rst = 1'b1;
        core_rsp_vld = 1'b1;
        tick();
        chk("mid_full", cmd_full_r, 0);
        chk("mid_rsp_vld", rsp_vld, 0);
        chk("mid_core_vld", core_cmd_vld, 0);
        chk("mid_core_cmd", core_cmd, 0);
        chk("mid_acc", core_rsp_accept, 0);
        chk("mid_err", {err_ovf_r, err_orphan_r}, 0);
        rst = 1'b0;
        core_rsp_vld = 1'b0;
        tick();
        tick();
        chk("mid_dropped", core_cmd_vld, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
